aes_result_signature: RTL and testbench

AES_RESULT_SIGNATURE -- requirements
Module: aes_result_signature

---
 rtl/aes_result_signature.sv | 172 +++++++++++++++++
 tb/tb_aes_result_signature.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_result_signature.sv
// Compresses a run of AES ciphertext blocks into a 128-bit MISR signature,
// requesting each encryption and guarding every wait with a watchdog.
module aes_result_signature #(
  parameter logic [31:0]  BLOCK_COUNT = 32'd1024,
  parameter logic [127:0] POLY        = 128'h87,
  parameter logic [31:0]  TIMEOUT     = 32'd4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_run,
  input  logic         finish,
  input  logic [127:0] data,
  output logic         next,
  output logic         busy,
  output logic         done,
  output logic [127:0] signature,
  output logic [31:0]  blocks,
  output logic         err_timeout,
  output logic         err_spurious
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_r;
  logic          finish_q_r;
  logic          next_r;
  logic          busy_r;
  logic          done_r;
  logic [127:0]  sig_r;
  logic [31:0]   blocks_r;
  logic [31:0]   wd_r;
  logic          err_timeout_r;
  logic          err_spurious_r;

  logic          fin_edge_s;
  logic [127:0]  sig_next_s;
  logic [31:0]   blocks_inc_s;
  logic [31:0]   wd_inc_s;

  // One MISR step: shift left, fold the carried-out bit back through POLY, mix in data.
  function automatic logic [127:0] misr_step(input logic [127:0] sig, input logic [127:0] din);
    logic [127:0] fb;
    if (sig[127]) begin
      fb = POLY;
    end else begin
      fb = 128'd0;
    end
    return {sig[126:0], 1'b0} ^ fb ^ din;
  endfunction

  // Edge detect on finish and precompute the next-value candidates.
  always_comb begin
    fin_edge_s   = finish & ~finish_q_r;
    sig_next_s   = misr_step(sig_r, data);
    blocks_inc_s = blocks_r + 32'd1;
    wd_inc_s     = wd_r + 32'd1;
  end

  // Run control FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= IDLE;
      finish_q_r     <= 1'b0;
      next_r         <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      sig_r          <= 128'd0;
      blocks_r       <= 32'd0;
      wd_r           <= 32'd0;
      err_timeout_r  <= 1'b0;
      err_spurious_r <= 1'b0;
    end else begin
      finish_q_r <= finish;
      if (start_run) begin
        // start_run outranks a coincident finish edge: nothing is absorbed or flagged.
        state_r        <= ARM;
        next_r         <= 1'b1;
        busy_r         <= 1'b1;
        done_r         <= 1'b0;
        sig_r          <= 128'd0;
        blocks_r       <= 32'd0;
        wd_r           <= 32'd0;
        err_timeout_r  <= 1'b0;
        err_spurious_r <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            next_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            if (fin_edge_s) begin
              err_spurious_r <= 1'b1;
            end else begin
              err_spurious_r <= err_spurious_r;
            end
          end
          ARM: begin
            state_r <= WAIT;
            next_r  <= 1'b0;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            wd_r    <= 32'd0;
            if (fin_edge_s) begin
              err_spurious_r <= 1'b1;
            end else begin
              err_spurious_r <= err_spurious_r;
            end
          end
          WAIT: begin
            if (fin_edge_s) begin
              sig_r    <= sig_next_s;
              blocks_r <= blocks_inc_s;
              if (blocks_inc_s == BLOCK_COUNT) begin
                state_r <= DONE;
                next_r  <= 1'b0;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
              end else begin
                state_r <= ARM;
                next_r  <= 1'b1;
                busy_r  <= 1'b1;
                done_r  <= 1'b0;
              end
            end else if (wd_inc_s == TIMEOUT) begin
              wd_r          <= wd_inc_s;
              err_timeout_r <= 1'b1;
              state_r       <= DONE;
              next_r        <= 1'b0;
              busy_r        <= 1'b0;
              done_r        <= 1'b1;
            end else begin
              wd_r   <= wd_inc_s;
              next_r <= 1'b0;
              busy_r <= 1'b1;
              done_r <= 1'b0;
            end
          end
          DONE: begin
            next_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            if (fin_edge_s) begin
              err_spurious_r <= 1'b1;
            end else begin
              err_spurious_r <= err_spurious_r;
            end
          end
          default: begin
            state_r <= IDLE;
            next_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign next         = next_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign signature    = sig_r;
  assign blocks       = blocks_r;
  assign err_timeout  = err_timeout_r;
  assign err_spurious = err_spurious_r;

endmodule

// File: tb/tb_aes_result_signature.sv
// Scenario bench for aes_result_signature with BLOCK_COUNT=2 and TIMEOUT=8;
// expected signatures come from a reference MISR model through a scoreboard queue.
module tb_aes_result_signature;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start_run = 1'b0;
  logic         finish = 1'b0;
  logic [127:0] data = 128'd0;
  logic         next;
  logic         busy;
  logic         done;
  logic [127:0] signature;
  logic [31:0]  blocks;
  logic         err_timeout;
  logic         err_spurious;

  int checks = 0;
  int errors = 0;
  int next_count = 0;
  logic [127:0] exp_sig = 128'd0;
  logic [31:0]  exp_blocks = 32'd0;
  logic [127:0] sb_q[$];

  aes_result_signature #(
    .BLOCK_COUNT(32'd2),
    .POLY(128'h87),
    .TIMEOUT(32'd8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_run(start_run),
    .finish(finish),
    .data(data),
    .next(next),
    .busy(busy),
    .done(done),
    .signature(signature),
    .blocks(blocks),
    .err_timeout(err_timeout),
    .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (next === 1'b1) next_count++;

  function automatic logic [127:0] model_step(input logic [127:0] s, input logic [127:0] d);
    logic [127:0] r;
    r = s << 1;
    if (s[127] == 1'b1) r = r ^ 128'h87;
    return r ^ d;
  endfunction

  task automatic start_pulse();
    start_run = 1'b1;
    @(negedge clk);
    start_run = 1'b0;
    exp_sig = 128'd0;
    exp_blocks = 32'd0;
    next_count = 0;
    sb_q.delete();
  endtask

  task automatic wait_next();
    int t;
    t = 0;
    while (next !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (next !== 1'b1) begin
      errors++;
      $display("FAIL wait_next: next=%b after %0d cycles, required 1", next, t);
    end
  endtask

  task automatic absorb(input logic [127:0] d, input int len, input bit in_wait);
    logic [127:0] e;
    if (!in_wait) wait_next();
    @(negedge clk);
    finish = 1'b1;
    data = d;
    exp_sig = model_step(exp_sig, d);
    exp_blocks++;
    sb_q.push_back(exp_sig);
    repeat (len) @(negedge clk);
    finish = 1'b0;
    e = sb_q.pop_front();
    checks++;
    if (signature !== e) begin
      errors++;
      $display("FAIL absorb_sig: got %h required %h", signature, e);
    end
    checks++;
    if (blocks !== exp_blocks) begin
      errors++;
      $display("FAIL absorb_blocks: got %0d required %0d", blocks, exp_blocks);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({next, busy, done, err_timeout, err_spurious, blocks, signature} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got n%b b%b d%b t%b s%b blk%0d sig%h required all 0",
               next, busy, done, err_timeout, err_spurious, blocks, signature);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({next, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: got next/busy/done %b%b%b required 000", next, busy, done);
    end
  endtask

  task automatic test_two_blocks();
    start_pulse();
    absorb(128'h1, 1, 1'b0);
    absorb(128'h1, 1, 1'b0);
    checks++;
    if (signature !== 128'h3) begin
      errors++;
      $display("FAIL two_sig: got %h required 3", signature);
    end
    checks++;
    if ({done, busy} !== 2'b10) begin
      errors++;
      $display("FAIL two_done: got done/busy %b%b required 10", done, busy);
    end
    checks++;
    if (next_count != 2) begin
      errors++;
      $display("FAIL two_next_count: got %0d required 2", next_count);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (signature !== 128'h3 || blocks !== 32'd2 || done !== 1'b1 || err_spurious !== 1'b0) begin
      errors++;
      $display("FAIL done_hold: got sig %h blk %0d done %b sp %b required 3/2/1/0",
               signature, blocks, done, err_spurious);
    end
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    checks++;
    if (err_spurious !== 1'b1 || signature !== 128'h3 || blocks !== 32'd2) begin
      errors++;
      $display("FAIL spurious_done: got sp %b sig %h blk %0d required 1/3/2",
               err_spurious, signature, blocks);
    end
  endtask

  task automatic test_feedback();
    logic [127:0] top;
    top = 128'd0;
    top[127] = 1'b1;
    start_pulse();
    absorb(top, 1, 1'b0);
    absorb(128'd0, 1, 1'b0);
    checks++;
    if (signature !== 128'h87) begin
      errors++;
      $display("FAIL feedback_sig: got %h required 87", signature);
    end
  endtask

  task automatic test_held_finish();
    start_pulse();
    absorb(128'hA5A5_5A5A_0123_4567_89AB_CDEF_F0F0_0F0F, 5, 1'b0);
    checks++;
    if ({busy, done, err_spurious} !== 3'b100) begin
      errors++;
      $display("FAIL held_state: got busy/done/sp %b%b%b required 100", busy, done, err_spurious);
    end
    absorb(128'h1234_5678_9ABC_DEF0_1122_3344_5566_7788, 1, 1'b1);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL held_done: got %b required 1", done);
    end
  endtask

  task automatic test_timeout();
    start_pulse();
    @(negedge clk);
    repeat (7) @(negedge clk);
    checks++;
    if ({done, busy, err_timeout} !== 3'b010) begin
      errors++;
      $display("FAIL timeout_early: got done/busy/to %b%b%b required 010", done, busy, err_timeout);
    end
    @(negedge clk);
    checks++;
    if ({done, busy, err_timeout} !== 3'b101) begin
      errors++;
      $display("FAIL timeout_fire: got done/busy/to %b%b%b required 101", done, busy, err_timeout);
    end
    checks++;
    if (blocks !== 32'd0 || signature !== 128'd0) begin
      errors++;
      $display("FAIL timeout_data: got blk %0d sig %h required 0/0", blocks, signature);
    end
  endtask

  task automatic test_spurious_idle();
    rst = 1'b0;
    #1;
    checks++;
    if ({done, err_timeout, err_spurious, blocks, signature} !== '0) begin
      errors++;
      $display("FAIL async_reset: got d%b t%b s%b blk%0d sig%h required all 0",
               done, err_timeout, err_spurious, blocks, signature);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    checks++;
    if (err_spurious !== 1'b1 || signature !== 128'd0 || blocks !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL spurious_idle: got sp %b sig %h blk %0d busy %b required 1/0/0/0",
               err_spurious, signature, blocks, busy);
    end
  endtask

  task automatic test_finish_across_reset();
    @(negedge clk);
    rst = 1'b0;
    finish = 1'b1;
    @(negedge clk);
    checks++;
    if (err_spurious !== 1'b0) begin
      errors++;
      $display("FAIL across_in_reset: got sp %b required 0", err_spurious);
    end
    rst = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    checks++;
    if (err_spurious !== 1'b1 || blocks !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL across_release: got sp %b blk %0d busy %b required 1/0/0",
               err_spurious, blocks, busy);
    end
  endtask

  task automatic test_reset_midrun();
    start_pulse();
    wait_next();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_busy: got %b required 1", busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({next, busy, done, err_timeout, err_spurious, blocks, signature} !== '0) begin
      errors++;
      $display("FAIL midrun_abort: got n%b b%b d%b blk%0d sig%h required all 0",
               next, busy, done, blocks, signature);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({next, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL midrun_stay_idle: got next/busy/done %b%b%b required 000", next, busy, done);
    end
    start_run = 1'b1;
    finish = 1'b1;
    data = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    start_run = 1'b0;
    checks++;
    if ({next, busy, err_spurious} !== 3'b110 || blocks !== 32'd0 || signature !== 128'd0) begin
      errors++;
      $display("FAIL collide_start: got n%b b%b sp%b blk%0d sig%h required 1/1/0/0/0",
               next, busy, err_spurious, blocks, signature);
    end
    @(negedge clk);
    finish = 1'b0;
    checks++;
    if (blocks !== 32'd0 || err_spurious !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL collide_after: got blk %0d sp %b busy %b required 0/0/1",
               blocks, err_spurious, busy);
    end
  endtask

  initial begin
    test_reset();
    test_two_blocks();
    test_feedback();
    test_held_finish();
    test_timeout();
    test_spurious_idle();
    test_finish_across_reset();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
